// File: rtl/mario_pkg.sv
// Shared definitions for the player movement slice: jump state encoding and
// bit positions inside the update_pos_scroll request vector.
package mario_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } move_state_t;

    // Request vector bit positions
    localparam int UPS_UP    = 3;
    localparam int UPS_DOWN  = 2;
    localparam int UPS_LEFT  = 1;
    localparam int UPS_RIGHT = 0;

    // Button slots used by the synchronizer bank in move_ctrl
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_JUMP  = 2;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous button level, with an optional
// rising-edge pulse taken from the synchronized level (EDGE_EN=1).
// With EDGE_EN=0 the btn_rise output is tied low.
module btn_sync
    import mario_pkg::*;
#(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic btn_lvl,
    output logic btn_rise
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw level through the two synchronizer stages
    always_comb begin
        sync_d = {sync_q[0], btn_async};
    end

    // Synchronizer flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign btn_lvl = sync_q[1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;
            logic prev_d;

            // Remember the previous synchronized level for edge detection
            always_comb begin
                prev_d = sync_q[1];
            end

            // Previous-level flop
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= prev_d;
                end
            end

            assign btn_rise = sync_q[1] & ~prev_q;
        end else begin : g_no_edge
            assign btn_rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/move_ctrl.sv
// Player movement controller: tick divider, GROUND/RISE/FALL jump state
// machine and a two-slot serializer that puts the vertical request at T+1
// and the horizontal request at T+2 after each tick cycle T, so at most one
// request bit is ever set.
// Optional feature macro: MOVE_VAR_JUMP_EN (releasing jump during RISE
// ends the rise at the next tick, giving a variable jump height).
module move_ctrl
    import mario_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int JUMP_H   = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       on_ground,
    output logic [3:0] update_pos_scroll,
    output logic       jump,
    output logic       fall
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(JUMP_H + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RISE_LAST = RW'(JUMP_H - 1);

    // ---------------- button synchronizers ----------------
    logic [2:0] btn_async;
    logic [2:0] btn_lvl;
    logic [2:0] btn_rise;

    assign btn_async[BTN_LEFT]  = btn_left;
    assign btn_async[BTN_RIGHT] = btn_right;
    assign btn_async[BTN_JUMP]  = btn_jump;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_sync #(
                .EDGE_EN (gi == BTN_JUMP)
            ) u_sync (
                .clk       (sys_clk),
                .rst       (rst),
                .btn_async (btn_async[gi]),
                .btn_lvl   (btn_lvl[gi]),
                .btn_rise  (btn_rise[gi])
            );
        end
    endgenerate

    // Only the jump instance has edge detection enabled, so the OR of all
    // edge outputs is exactly the jump rising edge.
    logic jump_edge;
    assign jump_edge = |btn_rise;

`ifndef MOVE_VAR_JUMP_EN
    // The jump level only matters for variable-height jumps.
    logic jump_lvl_unused;
    assign jump_lvl_unused = btn_lvl[BTN_JUMP];
`endif

    // ---------------- state ----------------
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] rise_cnt_q, rise_cnt_d;
    move_state_t   state_q, state_d;
    logic          jump_req_q, jump_req_d;
    logic [1:0]    h_pend_q, h_pend_d;
    logic [3:0]    ups_q, ups_d;
    logic          jump_q, jump_d;
    logic          fall_q, fall_d;
    logic          tick;

    // Next-state logic for divider, jump latch, state machine and slots
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        // A jump edge seen in the tick cycle itself survives into the next
        // tick window; anything older is dropped at the tick.
        jump_req_d = tick ? jump_edge : (jump_req_q | jump_edge);

        state_d    = state_q;
        rise_cnt_d = rise_cnt_q;
        ups_d      = '0;
        h_pend_d   = '0;

        if (tick) begin
            case (state_q)
                GROUND: begin
                    if (jump_req_q && on_ground) begin
                        state_d    = RISE;
                        rise_cnt_d = '0;
                    end else if (!on_ground) begin
                        state_d = FALL;
                    end
                end
                RISE: begin
`ifdef MOVE_VAR_JUMP_EN
                    if (!btn_lvl[BTN_JUMP]) begin
                        state_d = FALL;
                    end else
`endif
                    begin
                        ups_d[UPS_UP] = 1'b1;
                        rise_cnt_d    = rise_cnt_q + 1'b1;
                        if (rise_cnt_q == RISE_LAST) begin
                            state_d = FALL;
                        end
                    end
                end
                FALL: begin
                    if (on_ground) begin
                        state_d = GROUND;
                    end else begin
                        ups_d[UPS_DOWN] = 1'b1;
                    end
                end
                default: state_d = GROUND;
            endcase

            // Horizontal step is captured now and emitted one cycle later
            h_pend_d[UPS_LEFT]  = btn_lvl[BTN_LEFT] & ~btn_lvl[BTN_RIGHT];
            h_pend_d[UPS_RIGHT] = btn_lvl[BTN_RIGHT] & ~btn_lvl[BTN_LEFT];
        end else begin
            // h_pend_q is non-zero only in the cycle right after a tick
            ups_d[UPS_LEFT]  = h_pend_q[UPS_LEFT];
            ups_d[UPS_RIGHT] = h_pend_q[UPS_RIGHT];
        end

        jump_d = (state_d == RISE);
        fall_d = (state_d == FALL);
    end

    // All registered state and outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            rise_cnt_q <= '0;
            state_q    <= GROUND;
            jump_req_q <= 1'b0;
            h_pend_q   <= '0;
            ups_q      <= '0;
            jump_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            rise_cnt_q <= rise_cnt_d;
            state_q    <= state_d;
            jump_req_q <= jump_req_d;
            h_pend_q   <= h_pend_d;
            ups_q      <= ups_d;
            jump_q     <= jump_d;
            fall_q     <= fall_d;
        end
    end

    assign update_pos_scroll = ups_q;
    assign jump              = jump_q;
    assign fall              = fall_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl with TICK_DIV=4, JUMP_H=3.
// Phase bookkeeping: between tick_chk calls the bench sits in a tick cycle.
// on_ground changed there is seen by the tick checked in the next call;
// button changes need two synchronizer cycles and so show up one call later.
module tb_move_ctrl;

    logic       sys_clk;
    logic       rst;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic       on_ground;
    logic [3:0] update_pos_scroll;
    logic       jump;
    logic       fall;

    int n_cmp;
    int n_err;

    move_ctrl #(
        .TICK_DIV (4),
        .JUMP_H   (3)
    ) dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .btn_left          (btn_left),
        .btn_right         (btn_right),
        .btn_jump          (btn_jump),
        .on_ground         (on_ground),
        .update_pos_scroll (update_pos_scroll),
        .jump              (jump),
        .fall              (fall)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Consumes one full tick period starting from a tick cycle and checks
    // the vertical slot (T+1), horizontal slot (T+2) and two idle cycles.
    task automatic tick_chk(input string tag, input logic [3:0] ev, input logic [3:0] eh,
                            input logic ej, input logic ef);
        step();
        chk({tag, ".v"}, update_pos_scroll, ev);
        chk({tag, ".jump"}, {3'b0, jump}, {3'b0, ej});
        chk({tag, ".fall"}, {3'b0, fall}, {3'b0, ef});
        step();
        chk({tag, ".h"}, update_pos_scroll, eh);
        chk({tag, ".jump2"}, {3'b0, jump}, {3'b0, ej});
        step();
        chk({tag, ".idle0"}, update_pos_scroll, 4'b0000);
        step();
        chk({tag, ".idle1"}, update_pos_scroll, 4'b0000);
        $display("tick %s: ups_v=%b ups_h=%b jump=%b fall=%b", tag, ev, eh, ej, ef);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_jump  = 1'b0;
        on_ground = 1'b1;

        // ---- reset ----
        step();
        step();
        chk("rst.ups", update_pos_scroll, 4'b0000);
        chk("rst.jump", {3'b0, jump}, 4'b0000);
        chk("rst.fall", {3'b0, fall}, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst.ups", update_pos_scroll, 4'b0000);
        end
        tick_chk("idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // ---- walk right ----
        btn_right = 1'b1;
        tick_chk("right.sync", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick_chk("right.1", 4'b0000, 4'b0001, 1'b0, 1'b0);
        tick_chk("right.2", 4'b0000, 4'b0001, 1'b0, 1'b0);

        // ---- left and right together ----
        btn_left = 1'b1;
        tick_chk("both.sync", 4'b0000, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick_chk("both", 4'b0000, 4'b0000, 1'b0, 1'b0);
        end

        // ---- full jump ----
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_jump  = 1'b1;
        tick_chk("jump.sync", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick_chk("jump.enter", 4'b0000, 4'b0000, 1'b1, 1'b0);
        on_ground = 1'b0;
        tick_chk("jump.up1", 4'b1000, 4'b0000, 1'b1, 1'b0);
        tick_chk("jump.up2", 4'b1000, 4'b0000, 1'b1, 1'b0);
        tick_chk("jump.up3", 4'b1000, 4'b0000, 1'b0, 1'b1);
        tick_chk("jump.down1", 4'b0100, 4'b0000, 1'b0, 1'b1);
        tick_chk("jump.down2", 4'b0100, 4'b0000, 1'b0, 1'b1);
        on_ground = 1'b1;
        tick_chk("jump.land", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // ---- jump combined with walking right ----
        btn_jump = 1'b0;
        tick_chk("combo.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
        btn_jump  = 1'b1;
        btn_right = 1'b1;
        tick_chk("combo.sync", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick_chk("combo.enter", 4'b0000, 4'b0001, 1'b1, 1'b0);
        tick_chk("combo.up1", 4'b1000, 4'b0001, 1'b1, 1'b0);
        tick_chk("combo.up2", 4'b1000, 4'b0001, 1'b1, 1'b0);
        tick_chk("combo.up3", 4'b1000, 4'b0001, 1'b0, 1'b1);
        tick_chk("combo.land", 4'b0000, 4'b0001, 1'b0, 1'b0);

        // ---- variable jump: release jump after the first up step ----
        btn_jump  = 1'b0;
        btn_right = 1'b0;
        tick_chk("var.idle0", 4'b0000, 4'b0001, 1'b0, 1'b0);
        tick_chk("var.idle1", 4'b0000, 4'b0000, 1'b0, 1'b0);
        btn_jump = 1'b1;
        tick_chk("var.sync", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick_chk("var.enter", 4'b0000, 4'b0000, 1'b1, 1'b0);
        btn_jump = 1'b0;
        tick_chk("var.up1", 4'b1000, 4'b0000, 1'b1, 1'b0);
`ifdef MOVE_VAR_JUMP_EN
        tick_chk("var.cut", 4'b0000, 4'b0000, 1'b0, 1'b1);
`else
        tick_chk("var.up2", 4'b1000, 4'b0000, 1'b1, 1'b0);
        tick_chk("var.up3", 4'b1000, 4'b0000, 1'b0, 1'b1);
`endif
        tick_chk("var.land", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // ---- reset mid-operation with a horizontal request in flight ----
        btn_right = 1'b1;
        tick_chk("mid.sync", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step();
        chk("mid.pre_v", update_pos_scroll, 4'b0000);
        rst = 1'b1;
        #1;
        chk("mid.rst_now", update_pos_scroll, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid.rst_hold", update_pos_scroll, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.after", update_pos_scroll, 4'b0000);
        end
        tick_chk("mid.first_tick", 4'b0000, 4'b0001, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/move_ctrl.md
# move_ctrl

Player movement controller: converts synchronized button levels and a ground-contact flag into single-cycle step requests on `update_pos_scroll`, plus `jump`/`fall` status, for the character position block directly downstream. It runs a tick divider, a GROUND/RISE/FALL jump state machine and a two-slot serializer. The serializer guarantees at most one request bit per `sys_clk` cycle, so the downstream block never sees conflicting step requests.

## Interface
- `TICK_DIV`, 500000: `sys_clk` cycles per movement tick; must be ≥ 3.
- `JUMP_H`, 16: number of upward steps in a full jump; must be ≥ 1.
- `sys_clk` in 1: system clock; all state on rising edge.
- `rst` in 1: reset; asynchronous, active-high; one clock domain only.
- `btn_left` in 1: left button level, asynchronous to `sys_clk`.
- `btn_right` in 1: right button level, asynchronous.
- `btn_jump` in 1: jump button level, asynchronous.
- `on_ground` in 1: 1 when a solid block lies directly below the character; synchronous to `sys_clk`.
- `update_pos_scroll` out 4: one-cycle step requests.
  - bit3 = up (Y+1), bit2 = down (Y−1), bit1 = left (X−1), bit0 = right (X+1).
- `jump` out 1: registered, 1 while the state is RISE.
- `fall` out 1: registered, 1 while the state is FALL.

## Operation
- **Button inputs:** each button passes a 2-FF synchronizer. `btn_jump` additionally gets rising-edge detection on the synchronized level.
- **Jump request latch:** `jump_req` is set on a synchronized jump rising edge. It is cleared at every tick, whether or not it was used. Requests are never buffered across ticks.
- **Tick counter:** `tick_cnt` counts 0..TICK_DIV−1 and wraps. `tick` is asserted in the cycle where `tick_cnt == TICK_DIV−1`.
- **State machine:** transitions are evaluated only at `tick`, using `on_ground` sampled in the tick cycle.
  - **GROUND:**
    - `jump_req` && `on_ground` → RISE, `rise_cnt = 0`.
    - `!on_ground` → FALL.
    - Otherwise stay in GROUND.
    - No vertical request in any case.
  - **RISE:**
    - Schedule an up request and increment `rise_cnt`.
    - If `rise_cnt == JUMP_H−1`, go to FALL.
  - **FALL:**
    - `on_ground` → GROUND, no request.
    - Otherwise schedule a down request.
- **Horizontal step:** sampled at `tick`.
  - Only left held → left request.
  - Only right held → right request.
  - Both held or neither → no request.
- **Width rules:**
  - `rise_cnt` is `$clog2(JUMP_H+1)` bits.
  - `tick_cnt` is `$clog2(TICK_DIV)` bits.
  - Counters never saturate silently; `rise_cnt` is reset on RISE entry.

## Timing
- **Request slots:** with `tick` at cycle T:
  - the vertical request (if any) is driven in cycle T+1;
  - the horizontal request (if any) is driven in cycle T+2.
  - Each request lasts exactly one cycle; `update_pos_scroll` is 0 in all other cycles.
- **Status outputs:** `jump` and `fall` reflect the new state from cycle T+1.
- **Button latency:** 2 cycles of synchronizer delay, plus up to TICK_DIV cycles of tick alignment.
- **Simultaneous events:**
  - Jump edge in the tick cycle itself: it is latched and used at the next tick, not the current one.
  - Jump request while in RISE or FALL: dropped at the tick.
- **Reset values:**
  - `update_pos_scroll` = 0, `jump` = 0, `fall` = 0.
  - State GROUND; all counters, synchronizers and `jump_req` = 0.
- **Reset mid-operation:** an asserted `rst` immediately clears any pending or in-flight slot request. After release, counting restarts at 0, so the first tick falls TICK_DIV cycles after release.

## Configuration
- **`MOVE_VAR_JUMP_EN` defined:** in RISE, a synchronized `btn_jump` level of 0 at a tick moves the state to FALL with no up request that tick. The result is a variable jump height.
- **`MOVE_VAR_JUMP_EN` undefined:** every jump rises exactly JUMP_H steps regardless of the button.

## Structure
- **Shared package `mario_pkg`:**
  - state enum `move_state_t` {GROUND, RISE, FALL};
  - bit-index constants `UPS_UP=3`, `UPS_DOWN=2`, `UPS_LEFT=1`, `UPS_RIGHT=0`.
- **Sub-module `btn_sync`:** 2-FF synchronizer with optional rising-edge output, instantiated three times.
- **In `move_ctrl`:** the divider, state machine and slot serializer.

## Test plan
All scenarios use TICK_DIV=4, JUMP_H=3.
- **Reset:** hold `rst` for 5 cycles mid-tick → all outputs 0, first tick 4 cycles after release.
- **Walk right:** `btn_right`=1, `on_ground`=1 → `update_pos_scroll`=4'b0001 for 1 cycle at T+2 of every tick; never 4'b0010.
- **Left and right together:** both held → `update_pos_scroll` stays 0 for 5 ticks.
- **Full jump:** pulse `btn_jump`, `on_ground`=1, then drop `on_ground` to 0 → 3 ticks of 4'b1000 with `jump`=1, then `fall`=1 and 4'b0100 each tick. Raising `on_ground` → GROUND, no down request that tick.
- **Combined jump and walk:** jump plus `btn_right` → 4'b1000 at T+1 and 4'b0001 at T+2; never two bits set in the same cycle.
- **Variable jump (`MOVE_VAR_JUMP_EN`):** release `btn_jump` after the first up step → FALL at the next tick, only 1 up request total. Without the macro, 3 up requests.
